// File: rtl/product_host.sv
// product_host: drives an external nibble-serial product device.
// A transaction clears the device, streams op_a/op_b as four nibbles
// (low nibble first), then holds read high for RESULT_LAT cycles and
// captures dev_result into result_q, pulsing done for one cycle.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start, op_a, op_b    transaction request and operands (sampled in IDLE)
//   busy, done           transaction in progress / result-updated pulse
//   result_q             last captured device result
//   mismatch             self-check flag (0 unless PRODUCT_HOST_CHECK_EN)
//   dev_reset, read,     device clear strobe, read strobe and
//   nibble, dev_result   nibble bus; device result input
//
// Optional feature: define PRODUCT_HOST_CHECK_EN to compare each captured
// result against (op_a*op_b)[7:0] and report the outcome on mismatch.
module product_host #(
  parameter int unsigned RESULT_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result_q,
  output logic       mismatch,
  output logic       dev_reset,
  output logic       read,
  output logic [3:0] nibble,
  input  logic [7:0] dev_result
);

  localparam logic [3:0] LAST_SEND = 4'd3;
  localparam logic [3:0] LAST_WAIT = 4'(RESULT_LAT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SEND, WAIT, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] op_a_q, op_a_d;
  logic [7:0] op_b_q, op_b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       dev_reset_q, dev_reset_d;
  logic       read_q, read_d;
  logic [3:0] nibble_q, nibble_d;
  logic [7:0] result_d;
  logic       last_wait;

  // Nibble order on the device bus: a[3:0], a[7:4], b[3:0], b[7:4].
  function automatic logic [3:0] nib_sel(input logic [1:0] idx,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    case (idx)
      2'd0:    nib_sel = a[3:0];
      2'd1:    nib_sel = a[7:4];
      2'd2:    nib_sel = b[3:0];
      default: nib_sel = b[7:4];
    endcase
  endfunction

  assign last_wait = (state_q == WAIT) && (cnt_q == LAST_WAIT);

  // Next state; outputs are computed for the state being entered so the
  // registered copies line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dev_reset_d = 1'b0;
    read_d      = 1'b0;
    nibble_d    = 4'd0;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d     = CLEAR;
          op_a_d      = op_a;
          op_b_d      = op_b;
          busy_d      = 1'b1;
          dev_reset_d = 1'b1;
          cnt_d       = 4'd0;
        end
      end
      CLEAR: begin
        state_d  = SEND;
        cnt_d    = 4'd0;
        nibble_d = nib_sel(2'd0, op_a_q, op_b_q);
      end
      SEND: begin
        if (cnt_q == LAST_SEND) begin
          state_d = WAIT;
          cnt_d   = 4'd0;
          read_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q + 4'd1;
          nibble_d = nib_sel(2'(cnt_q + 4'd1), op_a_q, op_b_q);
        end
      end
      WAIT: begin
        // Counter stops at LAST_WAIT, so it never wraps.
        if (last_wait) begin
          state_d  = DONE;
          result_d = dev_result;
          done_d   = 1'b1;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          read_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_a_q      <= 8'd0;
      op_b_q      <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dev_reset_q <= 1'b0;
      read_q      <= 1'b0;
      nibble_q    <= 4'd0;
      result_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dev_reset_q <= dev_reset_d;
      read_q      <= read_d;
      nibble_q    <= nibble_d;
      result_q    <= result_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dev_reset = dev_reset_q;
  assign read      = read_q;
  assign nibble    = nibble_q;

`ifdef PRODUCT_HOST_CHECK_EN
  logic [7:0] prod_lo;
  logic       mismatch_q, mismatch_d;

  // Flag is refreshed on the same edge that loads result_q and raises done.
  always_comb begin
    prod_lo    = 8'(op_a_q * op_b_q);
    mismatch_d = mismatch_q;
    if (last_wait) begin
      mismatch_d = (dev_result != prod_lo);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_product_host.sv
// Bench for product_host: a main instance (RESULT_LAT=2) with a behavioural
// product device and a scoreboard, plus a RESULT_LAT=15 instance whose device
// returns the count of read cycles seen, exposing the sampling point.
module tb_product_host;
  localparam int unsigned LAT  = 2;
  localparam int unsigned LAT2 = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] op_a = 8'd0, op_b = 8'd0;
  logic [7:0] dev_result = 8'd0, dev_result2 = 8'd0;
  logic       busy, done, mismatch, dev_reset, read;
  logic [7:0] result_q;
  logic [3:0] nibble;
  logic       busy2, done2, mismatch2, dev_reset2, read2;
  logic [7:0] result_q2;
  logic [3:0] nibble2;

  product_host #(.RESULT_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result_q(result_q), .mismatch(mismatch),
    .dev_reset(dev_reset), .read(read), .nibble(nibble), .dev_result(dev_result));

  product_host #(.RESULT_LAT(LAT2)) dut15 (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy2), .done(done2), .result_q(result_q2), .mismatch(mismatch2),
    .dev_reset(dev_reset2), .read(read2), .nibble(nibble2), .dev_result(dev_result2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a, b, res;
    int         done_cyc;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0, n_fail = 0;

  // Transaction-level model of the host.
  bit         have_acc = 1'b0;
  int         acc_c = 0;
  logic [7:0] acc_a = 8'd0, acc_b = 8'd0;
  logic [7:0] last_res = 8'd0;
  logic       last_mis = 1'b0;

  // Device model state.
  int         ncnt = 4, rcnt = 0, rcnt2 = 0;
  logic [7:0] da = 8'd0, db = 8'd0;
  bit         ovr_en = 1'b0;
  logic [7:0] ovr_val = 8'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic logic exp_mismatch(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] res);
`ifdef PRODUCT_HOST_CHECK_EN
    return res != 8'(a * b);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor / scoreboard, followed by the device models.
  always @(negedge clk) begin : mon
    int         rel;
    logic [3:0] exp_nib;
    exp_t       e;
    if (reset) begin
      ncnt = 4; rcnt = 0; rcnt2 = 0; da = 8'd0; db = 8'd0;
      dev_result = 8'd0; dev_result2 = 8'd0;
    end else begin
      rel = cyc - acc_c;
      check("busy", busy, have_acc && rel >= 1 && rel <= 6 + LAT);
      check("dev_reset", dev_reset, have_acc && rel == 1);
      check("read", read, have_acc && rel >= 6 && rel <= 5 + LAT);
      exp_nib = 4'd0;
      if (have_acc && rel >= 2 && rel <= 5)
        exp_nib = 4'({acc_b, acc_a} >> (4 * (rel - 2)));
      check("nibble", nibble, exp_nib);

      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("result", result_q, e.res);
          check("mismatch", mismatch, exp_mismatch(e.a, e.b, e.res));
          check("dev_operands", {da, db}, {e.a, e.b});
          check("read_cycles", rcnt, LAT);
          last_res = e.res;
          last_mis = exp_mismatch(e.a, e.b, e.res);
        end
      end else begin
        check("result_hold", result_q, last_res);
        check("mismatch_hold", mismatch, last_mis);
      end
      if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
        check("done_timeout", 0, 1);
        void'(sb.pop_front());
      end

      if (done2) begin
        check("lat15_result", result_q2, LAT2);
        check("lat15_reads", rcnt2, LAT2);
      end

      // Main device: collects the four nibbles after a clear and returns
      // the low byte of the product, or a forced value.
      if (dev_reset) begin
        ncnt = 0; rcnt = 0; da = 8'd0; db = 8'd0;
      end else begin
        if (!read && busy && ncnt < 4) begin
          case (ncnt)
            0: da[3:0] = nibble;
            1: da[7:4] = nibble;
            2: db[3:0] = nibble;
            default: db[7:4] = nibble;
          endcase
          ncnt++;
        end
        if (read) rcnt++;
      end
      dev_result = ovr_en ? ovr_val : 8'(da * db);

      // Second device reports how many read cycles it has seen.
      if (dev_reset2) rcnt2 = 0;
      else if (read2) rcnt2++;
      dev_result2 = 8'(rcnt2);
    end
  end

  // Drive one cycle of stimulus and record any accepted transaction.
  task automatic step(input bit s, input logic [7:0] a, input logic [7:0] b,
                      input bit ovr, input logic [7:0] v);
    @(negedge clk);
    #2;
    start = s;
    op_a  = a;
    op_b  = b;
    if (s && !(have_acc && cyc <= acc_c + 6 + LAT)) begin
      have_acc = 1'b1;
      acc_c    = cyc;
      acc_a    = a;
      acc_b    = b;
      ovr_en   = ovr;
      ovr_val  = v;
      sb.push_back('{a: a, b: b, res: (ovr ? v : 8'(a * b)), done_cyc: cyc + 6 + LAT});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, 1'b0, 8'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_ctrl", {busy, done, read, dev_reset, nibble, mismatch}, 0);
    check("rst_result", result_q, 0);
    check("rst_lat15", {busy2, done2, read2, dev_reset2, result_q2}, 0);
  endtask

  // Assert reset between clock edges and check outputs clear without an edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    start = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    have_acc = 1'b0;
    last_res = 8'd0;
    last_mis = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs();
    #2;
    reset = 1'b0;

    // Known operands with a correct device, then a device returning zero.
    step(1'b1, 8'h23, 8'h45, 1'b0, 8'h00);
    idle(10);
    step(1'b1, 8'h23, 8'h45, 1'b1, 8'h00);
    idle(10);

    // A start during WAIT with new operands must be ignored.
    step(1'b1, 8'h23, 8'h45, 1'b0, 8'h00);
    idle(5);
    step(1'b1, 8'h11, 8'h22, 1'b0, 8'h00);
    idle(10);

    // Start held high: back-to-back transactions, operands changing freely.
    for (int i = 0; i < 30; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 1'b0, 8'h00);
    idle(12);

    // Reset during SEND aborts; the next transaction is normal.
    step(1'b1, 8'h5A, 8'hC3, 1'b0, 8'h00);
    idle(2);
    do_reset();
    idle(3);
    step(1'b1, 8'hF1, 8'h0E, 1'b0, 8'h00);
    idle(30);

    // Randomised traffic including forced device results.
    for (int i = 0; i < 400; i++)
      step(($urandom % 3) == 0, 8'($urandom), 8'($urandom),
           ($urandom % 4) == 0, 8'($urandom));
    idle(30);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
